// File: rtl/greenflow_uart_pkg.sv
// Shared constants, state encodings and frame helpers for the host command receiver.
package greenflow_uart_pkg;

  localparam logic [7:0] SYNC_BYTE    = 8'hA5;
  localparam logic [7:0] CMD_SET_KW   = 8'h01;
  localparam logic [7:0] CMD_SET_GRID = 8'h02;
  localparam logic [7:0] CMD_SET_TEMP = 8'h03;
  localparam logic [7:0] CMD_AI_CLEAR = 8'h04;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  typedef enum logic [2:0] {
    P_W_SYNC,
    P_W_CMD,
    P_W_HI,
    P_W_LO,
    P_W_CHK
  } parse_state_e;

  typedef struct packed {
    logic [7:0] cmd;
    logic [7:0] hi;
    logic [7:0] lo;
  } frame_t;

  function automatic logic frame_chk_ok(input frame_t f, input logic [7:0] chk);
    return chk == (f.cmd ^ f.hi ^ f.lo);
  endfunction

  function automatic logic cmd_known(input logic [7:0] cmd);
    return (cmd == CMD_SET_KW) || (cmd == CMD_SET_GRID) ||
           (cmd == CMD_SET_TEMP) || (cmd == CMD_AI_CLEAR);
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: 2-flop synchroniser followed by a mid-bit sampling FSM.
module uart_rx_byte
  import greenflow_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       byte_err
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  logic             rx_meta_q, rx_sync_q;
  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             byte_valid_q, byte_valid_d;
  logic             byte_err_q, byte_err_d;

  // Synchroniser presets to idle-high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= uart_rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RX_IDLE;
      clk_cnt_q    <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      byte_valid_q <= 1'b0;
      byte_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      clk_cnt_q    <= clk_cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      byte_valid_q <= byte_valid_d;
      byte_err_q   <= byte_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    clk_cnt_d    = clk_cnt_q + CNT_W'(1);
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    byte_err_d   = 1'b0;

    case (state_q)
      RX_IDLE: begin
        clk_cnt_d = '0;
        if (!rx_sync_q) state_d = RX_START;
      end
      RX_START: begin
        // A start bit that is gone by mid-bit was a glitch.
        if (clk_cnt_q == HALF_M1) begin
          clk_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = rx_sync_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (clk_cnt_q == FULL_M1) begin
          clk_cnt_d = '0;
          shift_d   = {rx_sync_q, shift_q[7:1]};
          if (bit_idx_q == 3'd7) state_d = RX_STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      RX_STOP: begin
        if (clk_cnt_q == FULL_M1) begin
          clk_cnt_d    = '0;
          state_d      = RX_IDLE;
          byte_valid_d = rx_sync_q;
          byte_err_d   = !rx_sync_q;
        end
      end
      default: begin
        state_d   = RX_IDLE;
        clk_cnt_d = '0;
      end
    endcase
  end

  assign byte_data  = shift_q;
  assign byte_valid = byte_valid_q;
  assign byte_err   = byte_err_q;

endmodule

// File: rtl/uart_cmd_rx.sv
// Host command receiver: parses SYNC/CMD/HI/LO/CHK frames into safety-core limits and requests.
module uart_cmd_rx
  import greenflow_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT  = 434,
  parameter int unsigned TIMEOUT_CLKS  = 20 * 434,
  parameter int unsigned AI_STALE_CLKS = 50_000_000,
  parameter logic [15:0] GRID_DEF      = 16'd0,
  parameter logic [15:0] TEMP_DEF      = 16'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_rx,
  output logic [15:0] llm_kw,
  output logic        ai_valid,
  output logic [15:0] grid_max,
  output logic [15:0] temp_max,
  output logic        frame_ok,
  output logic        frame_err
);

  localparam int unsigned TMO_W   = $clog2(TIMEOUT_CLKS + 1);
  localparam int unsigned STALE_W = $clog2(AI_STALE_CLKS + 1);
  localparam logic [TMO_W-1:0]   TMO_MAX   = TMO_W'(TIMEOUT_CLKS);
  localparam logic [STALE_W-1:0] STALE_MAX = STALE_W'(AI_STALE_CLKS);
  localparam logic [STALE_W-1:0] STALE_M1  = STALE_W'(AI_STALE_CLKS - 1);

  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_err;

  parse_state_e       pstate_q, pstate_d;
  frame_t             frame_q, frame_d;
  logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [STALE_W-1:0] stale_cnt_q, stale_cnt_d;
  logic [15:0]        llm_kw_q, llm_kw_d;
  logic               ai_valid_q, ai_valid_d;
  logic [15:0]        grid_max_q, grid_max_d;
  logic [15:0]        temp_max_q, temp_max_d;
  logic               frame_ok_q, frame_ok_d;
  logic               frame_err_q, frame_err_d;
  logic               set_kw;
  logic               tmo_expired;

  uart_rx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx_byte (
    .clk        (clk),
    .rst        (rst),
    .uart_rx    (uart_rx),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_err   (byte_err)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pstate_q    <= P_W_SYNC;
      frame_q     <= '0;
      tmo_cnt_q   <= '0;
      stale_cnt_q <= '0;
      llm_kw_q    <= 16'd0;
      ai_valid_q  <= 1'b0;
      grid_max_q  <= GRID_DEF;
      temp_max_q  <= TEMP_DEF;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      pstate_q    <= pstate_d;
      frame_q     <= frame_d;
      tmo_cnt_q   <= tmo_cnt_d;
      stale_cnt_q <= stale_cnt_d;
      llm_kw_q    <= llm_kw_d;
      ai_valid_q  <= ai_valid_d;
      grid_max_q  <= grid_max_d;
      temp_max_q  <= temp_max_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    pstate_d    = pstate_q;
    frame_d     = frame_q;
    tmo_cnt_d   = tmo_cnt_q;
    stale_cnt_d = stale_cnt_q;
    llm_kw_d    = llm_kw_q;
    ai_valid_d  = ai_valid_q;
    grid_max_d  = grid_max_q;
    temp_max_d  = temp_max_q;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    set_kw      = 1'b0;
    tmo_expired = 1'b0;

    // Inter-byte idle timer; only meaningful once a frame has started.
    if ((pstate_q == P_W_SYNC) || byte_valid) begin
      tmo_cnt_d = '0;
    end else if (tmo_cnt_q == TMO_MAX) begin
      tmo_expired = 1'b1;
    end else begin
      tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
    end

    case (pstate_q)
      P_W_SYNC: begin
        if (byte_valid && (byte_data == SYNC_BYTE)) pstate_d = P_W_CMD;
      end
      P_W_CMD: begin
        if (byte_valid) begin
          frame_d.cmd = byte_data;
          pstate_d    = P_W_HI;
        end
      end
      P_W_HI: begin
        if (byte_valid) begin
          frame_d.hi = byte_data;
          pstate_d   = P_W_LO;
        end
      end
      P_W_LO: begin
        if (byte_valid) begin
          frame_d.lo = byte_data;
          pstate_d   = P_W_CHK;
        end
      end
      P_W_CHK: begin
        if (byte_valid) begin
          pstate_d = P_W_SYNC;
          if (frame_chk_ok(frame_q, byte_data) && cmd_known(frame_q.cmd)) begin
            frame_ok_d = 1'b1;
            case (frame_q.cmd)
              CMD_SET_KW: begin
                llm_kw_d = {frame_q.hi, frame_q.lo};
                set_kw   = 1'b1;
              end
              CMD_SET_GRID: grid_max_d = {frame_q.hi, frame_q.lo};
              CMD_SET_TEMP: temp_max_d = {frame_q.hi, frame_q.lo};
              CMD_AI_CLEAR: ai_valid_d = 1'b0;
              default: ;
            endcase
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      default: pstate_d = P_W_SYNC;
    endcase

    // Line errors and host stalls abort any frame in progress.
    if ((pstate_q != P_W_SYNC) && (byte_err || tmo_expired)) begin
      pstate_d    = P_W_SYNC;
      tmo_cnt_d   = '0;
      frame_ok_d  = 1'b0;
      frame_err_d = 1'b1;
      set_kw      = 1'b0;
      llm_kw_d    = llm_kw_q;
      grid_max_d  = grid_max_q;
      temp_max_d  = temp_max_q;
      ai_valid_d  = ai_valid_q;
    end

    // Freshness timer; a same-cycle SET_KW beats expiry.
    if (set_kw) begin
      stale_cnt_d = '0;
      ai_valid_d  = 1'b1;
    end else if (ai_valid_q) begin
      if (stale_cnt_q == STALE_M1) begin
        stale_cnt_d = STALE_MAX;
        ai_valid_d  = 1'b0;
      end else if (stale_cnt_q != STALE_MAX) begin
        stale_cnt_d = stale_cnt_q + STALE_W'(1);
      end
    end
  end

  assign llm_kw    = llm_kw_q;
  assign ai_valid  = ai_valid_q;
  assign grid_max  = grid_max_q;
  assign temp_max  = temp_max_q;
  assign frame_ok  = frame_ok_q;
  assign frame_err = frame_err_q;

endmodule
